// File: rtl/mdio_pkg.sv
// mdio_pkg: shared opcodes, FSM states, register map and reset values for the MDIO responder
package mdio_pkg;
    typedef enum logic [2:0] {HUNT, ST, OP, PHYAD, REGAD, TA, RDATA, WDATA} state_t;
    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [4:0] REG_CTRL = 5'd0;
    localparam logic [4:0] REG_STAT = 5'd1;
    localparam logic [4:0] REG_ID1 = 5'd2;
    localparam logic [4:0] REG_ID2 = 5'd3;
    localparam logic [4:0] REG_MMD_CTL = 5'd13;
    localparam logic [4:0] REG_MMD_DATA = 5'd14;
    localparam logic [4:0] REG_PHYCTL = 5'd31;
    localparam logic [15:0] CTRL_RST = 16'h1140;
    localparam logic [15:0] CTRL_SC = 16'h8200;
    localparam logic [15:0] STAT_BASE = 16'h7949 | 16'h0020;
    localparam logic [31:0][15:0] RF_RST = {{31{16'h0000}}, CTRL_RST};
    function automatic logic is_ro(input logic [4:0] a);
        return a inside {REG_STAT, REG_ID1, REG_ID2, REG_PHYCTL};
    endfunction
endpackage

// File: rtl/mdio_responder_if.sv
// mdio_responder_if: MDC/MDIO pin bundle between station-management initiator and PHY target
interface mdio_responder_if;
    logic mdc;
    logic mdio_i;
    logic mdio_o;
    logic mdio_oe;
    modport master (output mdc, output mdio_i, input mdio_o, input mdio_oe);
    modport slave (input mdc, input mdio_i, output mdio_o, output mdio_oe);
endinterface

// File: rtl/mdio_sync_edge.sv
// mdio_sync_edge: synchronizes MDC/MDIO into the system clock and flags MDC rising edges
module mdio_sync_edge (
    input  logic clock,
    input  logic reset_n,
    input  logic mdc,
    input  logic mdio_i,
    output logic mdc_rise,
    output logic mdio_s
);
    logic [2:0] mdc_q, mdc_d;
    logic [1:0] dat_q, dat_d;
    always_comb begin
        mdc_d = {mdc_q[1:0], mdc};
        dat_d = {dat_q[0], mdio_i};
    end
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            mdc_q <= '0;
            dat_q <= '0;
        end else begin
            mdc_q <= mdc_d;
            dat_q <= dat_d;
        end
    assign mdc_rise = mdc_q[1] & ~mdc_q[2];
    assign mdio_s = dat_q[1];
endmodule

// File: rtl/mdio_responder.sv
// mdio_responder: Clause-22 MDIO target with 32x16 register file and reg 13/14 MMD indirect decode
module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR = 5'd0,
    parameter logic [15:0] PHY_ID1 = 16'h0022,
    parameter logic [15:0] PHY_ID2 = 16'h1620,
    parameter int          PRE_LEN = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    mdio_responder_if.slave mdio,
    input  logic        link_up,
    input  logic [1:0]  speed_in,
    input  logic        duplex_in,
    output logic        reg_wr,
    output logic [4:0]  reg_addr,
    output logic [15:0] reg_data,
    output logic        mmd_wr,
    output logic [4:0]  mmd_devad,
    output logic [15:0] mmd_regad,
    output logic [15:0] mmd_data,
    output logic        an_restart
);
    localparam int PW = $clog2(PRE_LEN + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(PRE_LEN);
    logic mdc_rise, mdio_s;
    mdio_sync_edge u_sync (
        .clock(clock), .reset_n(reset_n), .mdc(mdio.mdc), .mdio_i(mdio.mdio_i),
        .mdc_rise(mdc_rise), .mdio_s(mdio_s)
    );
    state_t state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [4:0] cnt_q, cnt_d, phy_q, phy_d, regad_q, regad_d;
    logic [1:0] op_q, op_d;
    logic [15:0] sh_q, sh_d;
    logic oe_q, oe_d, o_q, o_d;
    logic [31:0][15:0] rf_q, rf_d;
    logic reg_wr_q, reg_wr_d, mmd_wr_q, mmd_wr_d, an_restart_q, an_restart_d;
    logic [4:0] reg_addr_q, reg_addr_d, mmd_devad_q, mmd_devad_d;
    logic [15:0] reg_data_q, reg_data_d, mmd_regad_q, mmd_regad_d, mmd_data_q, mmd_data_d;
    logic [15:0] wdata, rd_val;
    logic [1:0] mmd_mode;
    logic ours, is_rd, last;
    assign wdata = {sh_q[14:0], mdio_s};
    assign is_rd = op_q == OP_RD;
    assign ours = phy_q == PHY_ADDR && (is_rd || op_q == OP_WR);
    assign last = cnt_q == 5'd16;
    assign mmd_mode = rf_q[REG_MMD_CTL][15:14];
    assign rd_val = regad_q == REG_STAT ? (STAT_BASE | (16'(link_up) << 2)) :
                    regad_q == REG_ID1 ? PHY_ID1 :
                    regad_q == REG_ID2 ? PHY_ID2 :
                    regad_q == REG_PHYCTL ? {9'b0, speed_in, 1'b0, duplex_in, 3'b0} : rf_q[regad_q];
    always_comb begin
        state_d = state_q; pre_d = pre_q; cnt_d = cnt_q; op_d = op_q; phy_d = phy_q;
        regad_d = regad_q; sh_d = sh_q; oe_d = oe_q; o_d = o_q; rf_d = rf_q;
        reg_wr_d = 1'b0; reg_addr_d = reg_addr_q; reg_data_d = reg_data_q;
        mmd_wr_d = 1'b0; mmd_devad_d = mmd_devad_q; mmd_regad_d = mmd_regad_q;
        mmd_data_d = mmd_data_q; an_restart_d = 1'b0;
        if (mdc_rise) begin
            case (state_q)
                HUNT: begin
                    pre_d = mdio_s ? (pre_q == PRE_MAX ? pre_q : pre_q + 1'b1) : '0;
                    state_d = (!mdio_s && pre_q == PRE_MAX) ? ST : HUNT;
                end
                ST: begin
                    state_d = mdio_s ? OP : HUNT;
                    cnt_d = '0;
                end
                OP: begin
                    op_d = {op_q[0], mdio_s};
                    cnt_d = cnt_q == 5'd1 ? '0 : cnt_q + 1'b1;
                    state_d = cnt_q == 5'd1 ? PHYAD : OP;
                end
                PHYAD: begin
                    phy_d = {phy_q[3:0], mdio_s};
                    cnt_d = cnt_q == 5'd4 ? '0 : cnt_q + 1'b1;
                    state_d = cnt_q == 5'd4 ? REGAD : PHYAD;
                end
                REGAD: begin
                    regad_d = {regad_q[3:0], mdio_s};
                    cnt_d = cnt_q == 5'd4 ? '0 : cnt_q + 1'b1;
                    state_d = cnt_q != 5'd4 ? REGAD : ours ? TA : HUNT;
                end
                TA: begin
                    cnt_d = cnt_q == 5'd0 ? 5'd1 : '0;
                    if (cnt_q == 5'd0) sh_d = is_rd ? rd_val : sh_q;
                    else begin
                        state_d = is_rd ? RDATA : WDATA;
                        oe_d = is_rd;
                        o_d = 1'b0;
                    end
                end
                // the hold rise doubles as the first preamble bit of the next frame
                RDATA: begin
                    oe_d = !last;
                    o_d = last ? 1'b0 : sh_q[15];
                    sh_d = {sh_q[14:0], 1'b0};
                    cnt_d = last ? '0 : cnt_q + 1'b1;
                    state_d = last ? HUNT : RDATA;
                    pre_d = last ? PW'(mdio_s) : pre_q;
                end
                WDATA: begin
                    sh_d = wdata;
                    cnt_d = cnt_q == 5'd15 ? '0 : cnt_q + 1'b1;
                    if (cnt_q == 5'd15) begin
                        state_d = HUNT;
                        reg_wr_d = 1'b1;
                        reg_addr_d = regad_q;
                        reg_data_d = wdata;
                        if (regad_q == REG_CTRL) begin
                            an_restart_d = wdata[9];
                            rf_d[REG_CTRL] = wdata & ~CTRL_SC;
                            if (wdata[15]) rf_d = RF_RST;
                        end else if (!is_ro(regad_q)) rf_d[regad_q] = wdata;
                        if (regad_q == REG_MMD_DATA) begin
                            mmd_devad_d = rf_q[REG_MMD_CTL][4:0];
                            mmd_wr_d = mmd_mode != 2'b00;
                            mmd_data_d = mmd_mode != 2'b00 ? wdata : mmd_data_q;
                            mmd_regad_d = mmd_mode == 2'b00 ? wdata :
                                          mmd_mode[1] ? mmd_regad_q + 1'b1 : mmd_regad_q;
                        end
                    end
                end
            endcase
        end
    end
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state_q <= HUNT; pre_q <= '0; cnt_q <= '0; op_q <= '0; phy_q <= '0;
            regad_q <= '0; sh_q <= '0; oe_q <= 1'b0; o_q <= 1'b0; rf_q <= RF_RST;
            reg_wr_q <= 1'b0; reg_addr_q <= '0; reg_data_q <= '0;
            mmd_wr_q <= 1'b0; mmd_devad_q <= '0; mmd_regad_q <= '0; mmd_data_q <= '0;
            an_restart_q <= 1'b0;
        end else begin
            state_q <= state_d; pre_q <= pre_d; cnt_q <= cnt_d; op_q <= op_d; phy_q <= phy_d;
            regad_q <= regad_d; sh_q <= sh_d; oe_q <= oe_d; o_q <= o_d; rf_q <= rf_d;
            reg_wr_q <= reg_wr_d; reg_addr_q <= reg_addr_d; reg_data_q <= reg_data_d;
            mmd_wr_q <= mmd_wr_d; mmd_devad_q <= mmd_devad_d; mmd_regad_q <= mmd_regad_d;
            mmd_data_q <= mmd_data_d; an_restart_q <= an_restart_d;
        end
    assign mdio.mdio_o = o_q;
    assign mdio.mdio_oe = oe_q;
    assign reg_wr = reg_wr_q;
    assign reg_addr = reg_addr_q;
    assign reg_data = reg_data_q;
    assign mmd_wr = mmd_wr_q;
    assign mmd_devad = mmd_devad_q;
    assign mmd_regad = mmd_regad_q;
    assign mmd_data = mmd_data_q;
    assign an_restart = an_restart_q;
endmodule

// File: tb/tb_mdio_responder.sv
// tb_mdio_responder: directed MDIO frames with hand-computed expectations
module tb_mdio_responder;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic link_up, duplex_in;
    logic [1:0] speed_in;
    logic reg_wr, mmd_wr, an_restart;
    logic [4:0] reg_addr, mmd_devad;
    logic [15:0] reg_data, mmd_regad, mmd_data;
    mdio_responder_if mif ();
    mdio_responder #(.PHY_ADDR(5'd0), .PHY_ID1(16'h0022), .PHY_ID2(16'h1620), .PRE_LEN(32)) dut (
        .clock(clock), .reset_n(reset_n), .mdio(mif), .link_up(link_up), .speed_in(speed_in),
        .duplex_in(duplex_in), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_data(reg_data),
        .mmd_wr(mmd_wr), .mmd_devad(mmd_devad), .mmd_regad(mmd_regad), .mmd_data(mmd_data),
        .an_restart(an_restart)
    );
    always #5 clock = ~clock;
    int n_chk = 0;
    int n_pass = 0;
    int wr_cnt = 0, mmd_cnt = 0, an_cnt = 0, oe_cnt = 0;
    always @(negedge clock) begin
        if (reg_wr) wr_cnt <= wr_cnt + 1;
        if (mmd_wr) mmd_cnt <= mmd_cnt + 1;
        if (an_restart) an_cnt <= an_cnt + 1;
        if (mif.mdio_oe) oe_cnt <= oe_cnt + 1;
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic cyc(input logic b);
        mif.mdc = 1'b0;
        mif.mdio_i = b;
        #80;
        mif.mdc = 1'b1;
        #80;
    endtask
    task automatic send(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) cyc(v[i]);
    endtask
    task automatic hdr(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra, input int npre);
        repeat (npre) cyc(1'b1);
        send({18'b0, 2'b01, op, phy, ra}, 14);
    endtask
    task automatic wr(input logic [4:0] ra, input logic [15:0] d, input int npre, input logic [4:0] phy);
        hdr(2'b01, phy, ra, npre);
        send({14'b0, 2'b10, d}, 18);
    endtask
    task automatic rd(input logic [4:0] ra, input logic [4:0] phy, output logic [15:0] d,
                      output logic oe1, output logic oe2, output logic o2, output logic oe_end);
        hdr(2'b10, phy, ra, 32);
        cyc(1'b1);
        oe1 = mif.mdio_oe;
        cyc(1'b1);
        oe2 = mif.mdio_oe;
        o2 = mif.mdio_o;
        for (int i = 15; i >= 0; i--) begin
            cyc(1'b1);
            d[i] = mif.mdio_o;
        end
        cyc(1'b1);
        oe_end = mif.mdio_oe;
    endtask
    task automatic rd_chk(input string tag, input logic [4:0] ra, input logic [15:0] exp);
        logic [15:0] d;
        logic a, b, c, e;
        rd(ra, 5'd0, d, a, b, c, e);
        check(tag, d, exp);
    endtask
    logic [15:0] rdv;
    logic oe1, oe2, o2, oe_e;
    int w0, m0, a0, x0;
    initial begin
        link_up = 1'b1;
        speed_in = 2'b00;
        duplex_in = 1'b0;
        mif.mdc = 1'b0;
        mif.mdio_i = 1'b1;
        #33 reset_n = 1'b1;
        #20;
        check("rst_out", {reg_wr, reg_addr, reg_data, mmd_wr, mmd_devad, an_restart, mif.mdio_oe, mif.mdio_o}, 0);
        check("rst_mmd", {mmd_regad, mmd_data}, 0);
        rd(5'd3, 5'd0, rdv, oe1, oe2, o2, oe_e);
        check("id2_oe_ta1", oe1, 0);
        check("id2_oe_ta2", oe2, 1);
        check("id2_o_ta2", o2, 0);
        check("id2_data", rdv, 16'h1620);
        check("id2_oe_end", oe_e, 0);
        w0 = wr_cnt;
        wr(5'd9, 16'h0200, 32, 5'd0);
        check("w9_cnt", wr_cnt - w0, 1);
        check("w9_addr", reg_addr, 9);
        check("w9_data", reg_data, 16'h0200);
        rd_chk("r9", 5'd9, 16'h0200);
        m0 = mmd_cnt;
        w0 = wr_cnt;
        wr(5'd13, 16'h0002, 32, 5'd0);
        wr(5'd14, 16'h0008, 32, 5'd0);
        check("mmd_addr_nowr", mmd_cnt - m0, 0);
        wr(5'd13, 16'h4002, 32, 5'd0);
        wr(5'd14, 16'h03FF, 32, 5'd0);
        check("mmd_cnt", mmd_cnt - m0, 1);
        check("mmd_regwr_cnt", wr_cnt - w0, 4);
        check("mmd_devad", mmd_devad, 2);
        check("mmd_regad", mmd_regad, 16'h0008);
        check("mmd_data", mmd_data, 16'h03FF);
        wr(5'd13, 16'h8002, 32, 5'd0);
        wr(5'd14, 16'h1111, 32, 5'd0);
        check("mmd_inc_cnt", mmd_cnt - m0, 2);
        check("mmd_inc_data", mmd_data, 16'h1111);
        check("mmd_inc_regad", mmd_regad, 16'h0009);
        w0 = wr_cnt;
        x0 = oe_cnt;
        wr(5'd9, 16'hBEEF, 32, 5'd5);
        rd(5'd3, 5'd5, rdv, oe1, oe2, o2, oe_e);
        check("phy5_wr", wr_cnt - w0, 0);
        check("phy5_oe", oe_cnt - x0, 0);
        wr(5'd9, 16'h0055, 32, 5'd0);
        w0 = wr_cnt;
        wr(5'd9, 16'h1234, 31, 5'd0);
        check("pre31_wr", wr_cnt - w0, 0);
        rd_chk("pre31_r9", 5'd9, 16'h0055);
        a0 = an_cnt;
        wr(5'd0, 16'h1300, 32, 5'd0);
        check("anr_pulse", an_cnt - a0, 1);
        rd_chk("r0_sc", 5'd0, 16'h1100);
        wr(5'd0, 16'h8000, 32, 5'd0);
        check("swrst_anr", an_cnt - a0, 1);
        rd_chk("swrst_r9", 5'd9, 16'h0000);
        rd_chk("swrst_r0", 5'd0, 16'h1140);
        speed_in = 2'b10;
        duplex_in = 1'b1;
        rd_chk("r31", 5'd31, 16'h0048);
        rd_chk("r1", 5'd1, 16'h796D);
        w0 = wr_cnt;
        hdr(2'b01, 5'd0, 5'd9, 32);
        send({22'b0, 2'b10, 8'hA5}, 10);
        #2000;
        send({24'b0, 8'h5A}, 8);
        check("mdc_stop_cnt", wr_cnt - w0, 1);
        check("mdc_stop_data", reg_data, 16'hA55A);
        hdr(2'b10, 5'd0, 5'd31, 32);
        repeat (7) cyc(1'b1);
        check("mid_rd_oe", mif.mdio_oe, 1);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("arst_oe", mif.mdio_oe, 0);
        #20 reset_n = 1'b1;
        #40;
        check("arst_out", {reg_addr, reg_data, mmd_regad}, 0);
        rd_chk("arst_r9", 5'd9, 16'h0000);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
